// File: rtl/mult_pipe_fu.sv
// mult_pipe_fu -- pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
//
// Elastic STAGES-deep pipeline. Each stage accumulates one CH-bit chunk of
// the extended rs2 operand (CH = 64/STAGES); the last stage holds the
// finished result until the CDB grants it. Empty stages are filled by
// their predecessor, so bubbles collapse and the only stall source is an
// ungranted result in the last stage.
//
// Build option: define MULT_SQUASH_EN to add the squash port, which drops
// every in-flight op (including the held result) at the next edge.
//
// Ports
//   clock, reset               clock; async active-low reset
//   in_valid/opa/opb/func      issue op (func 0=MUL 1=MULH 2=MULHSU 3=MULHU)
//   in_tag, in_rob_idx         destination tag / ROB entry, echoed on output
//   avail                      op offered this cycle is taken at the edge
//   out_valid/result/tag/rob_idx  held completed result
//   cdb_grant                  CDB takes the held result at the edge
//   squash                     (MULT_SQUASH_EN) kill all in-flight ops

// One accumulation step: acc + opa * chunk, chunk weighted by K*CH bits.
module mult_pipe_step #(
  parameter int K  = 0,
  parameter int CH = 16
) (
  input  logic [63:0]   opa,
  input  logic [CH-1:0] chunk,
  input  logic [63:0]   acc,
  output logic [63:0]   acc_nxt
);
  logic [63:0] pp;

  assign pp      = opa * 64'(chunk);
  assign acc_nxt = acc + (pp << (K * CH));
endmodule

module mult_pipe_fu #(
  parameter int STAGES = 4,   // 1, 2, 4 or 8 (must divide 64)
  parameter int TAG_W  = 6,
  parameter int ROB_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_opa,
  input  logic [31:0]      in_opb,
  input  logic [1:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [ROB_W-1:0] in_rob_idx,
  output logic             avail,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [ROB_W-1:0] out_rob_idx,
  input  logic             cdb_grant
`ifdef MULT_SQUASH_EN
  ,
  input  logic             squash
`endif
);
  localparam int CH = 64 / STAGES;

  localparam logic [1:0] F_MUL    = 2'd0;
  localparam logic [1:0] F_MULH   = 2'd1;
  localparam logic [1:0] F_MULHSU = 2'd2;

  typedef struct packed {
    logic [63:0]      opa;
    logic [63:0]      opb;
    logic [63:0]      acc;
    logic [1:0]       func;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } stage_t;

  logic [STAGES-1:0]       vld_pipe;  // stage valid bits, [STAGES-1] = out_valid
  logic [STAGES-1:0]       load;      // stage k takes its predecessor's content
  logic [STAGES-1:0]       src_vld;
  stage_t [STAGES-1:0]     stg_q;
  stage_t [STAGES-1:0]     src;       // what would enter stage k this edge
  logic [STAGES-1:0][63:0] acc_nxt;
  logic [31:0]             res_nxt;
  logic                    kill;

`ifdef MULT_SQUASH_EN
  assign kill = squash;
`else
  assign kill = 1'b0;
`endif

  // A stage can load when it is empty or its content is leaving; the
  // last stage's content leaves on grant. Chain from the output backwards.
  always_comb begin : advance
    logic go;
    load = '0;
    go   = !vld_pipe[STAGES-1] || cdb_grant;
    load[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go      = !vld_pipe[k] || go;
      load[k] = go;
    end
  end

  assign avail = load[0];

  // Stage 0 source is the issue port with operands extended per func;
  // every other stage sources its predecessor.
  always_comb begin : sources
    logic sx_a, sx_b;
    sx_a    = (in_func == F_MULH) || (in_func == F_MULHSU);
    sx_b    = (in_func == F_MULH);
    src     = '0;
    src_vld = '0;
    src_vld[0]  = in_valid;
    src[0].opa  = {{32{sx_a & in_opa[31]}}, in_opa};
    src[0].opb  = {{32{sx_b & in_opb[31]}}, in_opb};
    src[0].func = in_func;
    src[0].tag  = in_tag;
    src[0].rob  = in_rob_idx;
    for (int k = 1; k < STAGES; k++) begin
      src[k]     = stg_q[k-1];
      src_vld[k] = vld_pipe[k-1];
    end
  end

  // Stage k adds chunk k of opb as the op enters it.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_pipe_step #(.K(k), .CH(CH)) u_step (
      .opa     (src[k].opa),
      .chunk   (src[k].opb[k*CH +: CH]),
      .acc     (src[k].acc),
      .acc_nxt (acc_nxt[k])
    );
  end

  assign res_nxt = (src[STAGES-1].func == F_MUL) ? acc_nxt[STAGES-1][31:0]
                                                 : acc_nxt[STAGES-1][63:32];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe   <= '0;
      stg_q      <= '0;
      out_result <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (kill)         vld_pipe[k] <= 1'b0;
        else if (load[k]) vld_pipe[k] <= src_vld[k];
        // Payload only moves with a real op so a held result never
        // gets overwritten by a bubble.
        if (load[k] && src_vld[k]) begin
          stg_q[k]     <= src[k];
          stg_q[k].acc <= acc_nxt[k];
        end
      end
      if (load[STAGES-1] && src_vld[STAGES-1]) out_result <= res_nxt;
    end
  end

  assign out_valid   = vld_pipe[STAGES-1];
  assign out_tag     = stg_q[STAGES-1].tag;
  assign out_rob_idx = stg_q[STAGES-1].rob;

  // The last stage only needs tag/rob; its operand copies are dead.
  logic unused_last;
  assign unused_last = ^{stg_q[STAGES-1].opa, stg_q[STAGES-1].opb,
                         stg_q[STAGES-1].acc, stg_q[STAGES-1].func};
endmodule
